// File: rtl/adc_pkg.sv
// adc_pkg
// Shared definitions for the ADC sample path.
//   ADC_DATA_W  : native sample width of the XADC wrapper bus
//   adc_state_e : run/idle state of the decimator
//   ob_to_tc()  : offset-binary to two's-complement conversion
package adc_pkg;

    localparam int ADC_DATA_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } adc_state_e;

    // Offset binary puts mid-scale at 100..0. Inverting the MSB maps that
    // code to zero and leaves the remaining bits as a two's-complement value.
    function automatic logic [ADC_DATA_W-1:0] ob_to_tc(input logic [ADC_DATA_W-1:0] raw);
        return {~raw[ADC_DATA_W-1], raw[ADC_DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/adc_ready_watchdog.sv
// adc_ready_watchdog
// Counts clock cycles since the last ready strobe and raises a sticky stall
// flag when the gap reaches TIMEOUT_CYC.
//   clk_i     : system clock, rising edge
//   rst_i     : asynchronous active-high reset
//   run_i     : counting enabled (decimator in RUN with enable asserted)
//   ready_i   : converter ready strobe; restarts the gap count
//   clear_i   : clears the sticky stall flag
//   stall_o   : sticky stall flag
//   timeout_o : single-cycle pulse in the cycle the gap count reaches TIMEOUT_CYC
module adc_ready_watchdog
    import adc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic ready_i,
    input  logic clear_i,
    output logic stall_o,
    output logic timeout_o
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             stall_q, stall_d;
    logic             timeout;

    always_comb begin
        gap_d   = gap_q;
        timeout = 1'b0;
        if (!run_i || ready_i) begin
            // A strobe in the would-be timeout cycle wins: no stall is raised.
            gap_d = '0;
        end else if (gap_q != GAP_W'(TIMEOUT_CYC)) begin
            gap_d   = gap_q + GAP_W'(1);
            timeout = (gap_q == GAP_W'(TIMEOUT_CYC - 1));
        end
    end

    // Set has priority over clear so a coincident timeout is never lost.
    always_comb begin
        stall_d = stall_q;
        if (timeout) begin
            stall_d = 1'b1;
        end else if (clear_i) begin
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gap_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            gap_q   <= gap_d;
            stall_q <= stall_d;
        end
    end

    assign stall_o   = stall_q;
    assign timeout_o = timeout;

endmodule

// File: rtl/adc_sample_decimator.sv
// adc_sample_decimator
// Converts offset-binary ADC samples to two's complement and averages each
// group of 2^LOG2_DEC samples into one signed output sample.
//   clk_78MHz_i   : system clock, rising edge
//   reset_i       : asynchronous active-high reset
//   enable_i      : 1 = run, 0 = flush partial group and ignore input
//   data_i        : unsigned offset-binary sample, valid while ready_i is high
//   ready_i       : single-cycle sample strobe
//   clear_stall_i : clears stall_o
//   data_o        : signed decimated sample, held between pulses
//   valid_o       : single-cycle pulse, data_o is new in this cycle
//   stall_o       : sticky sample-gap watchdog flag
//   state_o       : current FSM state, for observation only
//
// Handshake: there is no back-pressure. ready_i marks a sample on data_i in
// that one cycle only; valid_o marks a new data_o in that one cycle only, two
// cycles after the ready_i that completes a group.
module adc_sample_decimator
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int LOG2_DEC    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_78MHz_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    input  logic              clear_stall_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              stall_o,
    output adc_state_e        state_o
);

    localparam int DEC   = 1 << LOG2_DEC;
    localparam int ACC_W = DATA_W + LOG2_DEC;
    localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;

    adc_state_e               state_q, state_d;
    logic [DATA_W-1:0]        s1_q, s1_d;
    logic                     s1_v_q, s1_v_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     valid_q, valid_d;

    logic [DATA_W-1:0]        conv;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic                     last_in_group;
    logic                     run;
    logic                     timeout;

    // ------------------------------------------------------------------
    // Offset-binary conversion
    // ------------------------------------------------------------------
    if (DATA_W == ADC_DATA_W) begin : g_pkg_conv
        assign conv = ob_to_tc(data_i);
    end else begin : g_wide_conv
        assign conv = {~data_i[DATA_W-1], data_i[DATA_W-2:0]};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i)  state_d = RUN;
            RUN:     if (!enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign run = (state_q == RUN) && enable_i;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    adc_ready_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i     (clk_78MHz_i),
        .rst_i     (reset_i),
        .run_i     (run),
        .ready_i   (ready_i),
        .clear_i   (clear_stall_i),
        .stall_o   (stall_o),
        .timeout_o (timeout)
    );

    // ------------------------------------------------------------------
    // Stage 1: capture and convert
    // ------------------------------------------------------------------
    always_comb begin
        s1_d   = s1_q;
        s1_v_d = ready_i && enable_i;
        if (ready_i && enable_i) begin
            s1_d = conv;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate and emit
    // ------------------------------------------------------------------
    // The accumulator carries LOG2_DEC guard bits, so a full group of
    // extreme samples cannot overflow before the shift.
    assign sum           = acc_q + ACC_W'($signed(s1_q));
    assign shifted       = sum >>> LOG2_DEC;
    assign last_in_group = (LOG2_DEC == 0) || (cnt_q == CNT_W'(DEC - 1));

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (!enable_i || timeout) begin
            // Leaving RUN or a converter stall drops any partial group and
            // any sample still in stage 1, so the next output is aligned.
            acc_d = '0;
            cnt_d = '0;
        end else if (s1_v_q) begin
            if (last_in_group) begin
                data_d  = shifted[DATA_W-1:0];
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_78MHz_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s1_v_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s1_v_q  <= s1_v_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_adc_sample_decimator.sv
// tb_adc_sample_decimator
// Drives ADC samples into adc_sample_decimator and scores the decimated output
// against an arithmetic reference (mean of each group, rounded toward minus
// infinity) and a cycle-count model of the sample-gap watchdog.
module tb_adc_sample_decimator;
    import adc_pkg::*;

    localparam int DEC = 4;
    localparam int TO  = 1024;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [11:0] data_i;
    logic        ready_i;
    logic        clear_stall_i;
    logic [11:0] data_o;
    logic        valid_o;
    logic        stall_o;
    adc_state_e  state_o;

    always #5 clk = ~clk;

    adc_sample_decimator #(
        .DATA_W      (12),
        .LOG2_DEC    (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_78MHz_i   (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .data_i        (data_i),
        .ready_i       (ready_i),
        .clear_stall_i (clear_stall_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .stall_o       (stall_o),
        .state_o       (state_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [11:0] exp_q[$];
    int          exp_cyc_q[$];
    int          grp[$];        // signed sample values of the open group
    bit          pend;          // a sample was strobed in the previous cycle
    int          pend_val;
    int          m_gap;
    bit          prev_en;
    bit          m_stall;
    bit          done = 1'b0;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // One clock cycle of stimulus. The model works out what the edge at the
    // end of this cycle does, and commits the watchdog flag after the edge.
    task automatic drive(input bit en, input bit rdy, input logic [11:0] d, input bit clr);
        bit to;
        bit next_stall;
        int s;
        int q;
        enable_i      = en;
        ready_i       = rdy;
        data_i        = d;
        clear_stall_i = clr;
        to = 1'b0;
        if (!en) begin
            grp.delete();
            pend  = 1'b0;
            m_gap = 0;
        end else begin
            if (rdy) begin
                m_gap = 0;
            end else if (prev_en && m_gap < TO) begin
                m_gap++;
                if (m_gap == TO) to = 1'b1;
            end
            if (to) begin
                grp.delete();
            end else if (pend) begin
                grp.push_back(pend_val);
                if (grp.size() == DEC) begin
                    s = 0;
                    foreach (grp[i]) s += grp[i];
                    q = s / DEC;
                    if (s < 0 && (s % DEC) != 0) q--;
                    exp_q.push_back(12'(q));
                    exp_cyc_q.push_back(cyc + 1);
                    grp.delete();
                end
            end
        end
        next_stall = to ? 1'b1 : (clr ? 1'b0 : m_stall);
        pend       = rdy && en;
        pend_val   = int'(d) - 2048;
        prev_en    = en;
        @(posedge clk);
        #1;
        m_stall = next_stall;
    endtask

    task automatic send(input logic [11:0] d);
        drive(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 12'($urandom_range(0, 4095)), 1'b0);
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        enable_i      = 1'b0;
        ready_i       = 1'b0;
        clear_stall_i = 1'b0;
        data_i        = '0;
        grp.delete();
        pend    = 1'b0;
        m_gap   = 0;
        prev_en = 1'b0;
        m_stall = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset_i = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / monitor
    // ------------------------------------------------------------------
    logic [11:0] last_out = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] e;
        int          ec;
        if (reset_i) begin
            chk("reset_valid", int'(valid_o), 0);
            chk("reset_data", int'(data_o), 0);
            chk("reset_stall", int'(stall_o), 0);
            last_out = '0;
        end else begin
            while (exp_cyc_q.size() != 0 && exp_cyc_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_output due at cycle %0d: got none expected 0x%0h",
                         exp_cyc_q[0], exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid at cycle %0d: got data 0x%0h expected no pulse",
                             cyc, data_o);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("data", int'(data_o), int'(e));
                    chk("latency_cycle", cyc, ec);
                    last_out = e;
                end
            end else begin
                chk("data_hold", int'(data_o), int'(last_out));
            end
            chk("stall", int'(stall_o), int'(m_stall));
        end
        if (done) begin
            chk("outputs_drained", exp_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        do_reset();

        // After reset with no samples, the watchdog trips once, then clear.
        idle(TO + 20);
        drive(1'b1, 1'b0, 12'h000, 1'b1);
        idle(3);

        // Directed groups.
        repeat (4) send(12'h800);
        idle(3);
        repeat (4) send(12'hFFF);
        idle(3);
        repeat (4) send(12'h000);
        idle(3);
        send(12'h801); send(12'h801); send(12'h802); send(12'h802);
        idle(3);
        repeat (3) send(12'h7FF);
        send(12'h800);
        idle(3);

        // Back-to-back strobes.
        repeat (8) send(12'hC00);
        idle(3);

        // Enable drop right after a strobe discards the partial group.
        send(12'h123);
        send(12'h456);
        for (int i = 0; i < 3; i++) drive(1'b0, i[0], 12'hFFF, 1'b0);
        idle(3);
        repeat (4) send(12'h900);
        idle(3);

        // Randomized traffic, including strobes while disabled.
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(1, 3))
                    drive(1'b0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 1'b0);
            end else begin
                send(12'($urandom_range(0, 4095)));
                idle($urandom_range(0, 2));
            end
        end
        idle(4);

        // Reset in the middle of a group produces nothing from that group.
        send(12'hFFF);
        send(12'hFFF);
        do_reset();
        repeat (4) send(12'h800);
        idle(3);

        // Watchdog: partial group, then a gap that reaches the timeout.
        send(12'hFFF);
        send(12'hFFF);
        idle(TO + 10);
        repeat (4) send(12'h800);
        idle(3);
        drive(1'b1, 1'b0, 12'h000, 1'b1);

        // Clear coinciding with a new timeout: set wins.
        send(12'h800);
        idle(TO - 1);
        drive(1'b1, 1'b0, 12'h000, 1'b1);
        idle(3);
        drive(1'b1, 1'b0, 12'h000, 1'b1);

        // Strobe coinciding with the would-be timeout: no stall.
        send(12'hA00);
        idle(TO - 1);
        send(12'hA00);
        send(12'hA00);
        send(12'hA00);
        idle(5);

        done = 1'b1;
    end

    initial begin
        #10_000_000;
        $display("FAIL time_limit: got no end of test expected completion");
        $fatal(1, "time limit");
    end

endmodule
